// File: rtl/z_capture.sv
// z_capture: records a 17-step Z_IN match stream into MASK, one bit per P_0 step,
// with an idle-cycle timeout that aborts into DONE with ERR set.
// Optional feature macro ZCAP_DOUBLE_PASS_EN: a second verify pass (CAPT2)
// re-runs the 17 steps and flags any disagreement with the first pass on MISMATCH.
module z_capture #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        P_0,
  input  logic        Z_IN,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        MISMATCH,
  output logic [16:0] MASK,
  output logic [4:0]  STEP
);

  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];
  localparam logic [4:0]  LAST_STEP   = 5'd16;

`ifdef ZCAP_DOUBLE_PASS_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CAPT2 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`endif

  state_t      state, next_state;
  logic [15:0] idle_cnt;
  logic [15:0] idle_next;
  logic        clear;
  logic        take_step;
  logic        idle_inc;
  logic        abort;
  state_t      pass_end_state;

  assign idle_next = idle_cnt + 16'd1;

`ifdef ZCAP_DOUBLE_PASS_EN
  assign pass_end_state = (state == ST_CAPT) ? ST_CAPT2 : ST_DONE;
  assign BUSY           = (state == ST_CAPT) || (state == ST_CAPT2);
`else
  assign pass_end_state = ST_DONE;
  assign BUSY           = (state == ST_CAPT);
`endif
  assign DONE = (state == ST_DONE);

  // State register
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus the per-cycle datapath controls
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    take_step  = 1'b0;
    idle_inc   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          next_state = ST_CAPT;
          clear      = 1'b1;
        end
      end
      ST_DONE: begin
        // a new START wins over ACK
        if (START) begin
          next_state = ST_CAPT;
          clear      = 1'b1;
        end else if (ACK) begin
          next_state = ST_IDLE;
        end
      end
`ifdef ZCAP_DOUBLE_PASS_EN
      ST_CAPT, ST_CAPT2: begin
`else
      ST_CAPT: begin
`endif
        if (P_0) begin
          take_step = 1'b1;
          if (STEP == LAST_STEP) next_state = pass_end_state;
        end else begin
          idle_inc = 1'b1;
          if (idle_next == TIMEOUT_CNT) begin
            abort      = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture datapath: mask bits, step index, idle counter and the sticky flags
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      MASK     <= '0;
      STEP     <= '0;
      ERR      <= 1'b0;
      idle_cnt <= '0;
    end else if (clear) begin
      MASK     <= '0;
      STEP     <= '0;
      ERR      <= 1'b0;
      idle_cnt <= '0;
    end else if (take_step) begin
      idle_cnt <= '0;
      STEP     <= (STEP == LAST_STEP) ? 5'd0 : STEP + 5'd1;
      if (state == ST_CAPT) MASK[STEP] <= Z_IN;
    end else if (idle_inc) begin
      idle_cnt <= idle_next;
      if (abort) ERR <= 1'b1;
    end
  end

`ifdef ZCAP_DOUBLE_PASS_EN
  logic mismatch_q;

  // Verify pass: any step disagreeing with the first-pass bit sets the flag
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      mismatch_q <= 1'b0;
    end else if (clear) begin
      mismatch_q <= 1'b0;
    end else if (take_step && (state == ST_CAPT2) && (Z_IN != MASK[STEP])) begin
      mismatch_q <= 1'b1;
    end
  end

  assign MISMATCH = mismatch_q;
`else
  assign MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_z_capture.sv
// tb_z_capture: two z_capture instances (TIMEOUT 255 and 4) driven by the same
// stimulus, compared every cycle against a behavioural model, plus literal checks.
module tb_z_capture;

  logic CK = 1'b0, RN = 1'b0, START = 1'b0, P_0 = 1'b0, Z_IN = 1'b0, ACK = 1'b0;
  logic        busy [2];
  logic        done_o [2];
  logic        err [2];
  logic        mis [2];
  logic [16:0] mask [2];
  logic [4:0]  step [2];
  int checks = 0;
  int errors = 0;

`ifdef ZCAP_DOUBLE_PASS_EN
  localparam bit DOUBLE = 1'b1;
`else
  localparam bit DOUBLE = 1'b0;
`endif
  localparam int TO0 = 255;
  localparam int TO1 = 4;

  z_capture #(.TIMEOUT(TO0)) dut0 (
    .CK(CK), .RN(RN), .START(START), .P_0(P_0), .Z_IN(Z_IN), .ACK(ACK),
    .BUSY(busy[0]), .DONE(done_o[0]), .ERR(err[0]), .MISMATCH(mis[0]),
    .MASK(mask[0]), .STEP(step[0])
  );

  z_capture #(.TIMEOUT(TO1)) dut1 (
    .CK(CK), .RN(RN), .START(START), .P_0(P_0), .Z_IN(Z_IN), .ACK(ACK),
    .BUSY(busy[1]), .DONE(done_o[1]), .ERR(err[1]), .MISMATCH(mis[1]),
    .MASK(mask[1]), .STEP(step[1])
  );

  always #5 CK = ~CK;

  // Behavioural model: phase name, captured bits, step index, flags, idle run length
  typedef enum int { M_IDLE, M_CAPT, M_CAPT2, M_DONE } phase_t;
  typedef struct {
    phase_t      ph;
    logic [16:0] bits;
    int          idx;
    bit          err;
    bit          mis;
    int          idle;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mfresh(input phase_t ph);
    mdl_t r;
    r.ph = ph; r.bits = '0; r.idx = 0; r.err = 1'b0; r.mis = 1'b0; r.idle = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input int to, input bit st, input bit p,
                                 input bit z, input bit ack);
    mdl_t n = c;
    if (c.ph == M_IDLE || c.ph == M_DONE) begin
      if (st) n = mfresh(M_CAPT);
      else if (c.ph == M_DONE && ack) n.ph = M_IDLE;
    end else if (p) begin
      n.idle = 0;
      if (c.ph == M_CAPT) n.bits[c.idx] = z;
      else if (c.bits[c.idx] != z) n.mis = 1'b1;
      if (c.idx == 16) begin
        n.idx = 0;
        n.ph  = (c.ph == M_CAPT && DOUBLE) ? M_CAPT2 : M_DONE;
      end else begin
        n.idx = c.idx + 1;
      end
    end else begin
      n.idle = c.idle + 1;
      if (n.idle == to) begin
        n.ph  = M_DONE;
        n.err = 1'b1;
      end
    end
    return n;
  endfunction

  // Model advances on every clock edge; asynchronous reset clears it immediately
  initial begin
    m[0] = mfresh(M_IDLE);
    m[1] = mfresh(M_IDLE);
    forever begin
      @(posedge CK or negedge RN);
      if (!RN) begin
        m[0] = mfresh(M_IDLE);
        m[1] = mfresh(M_IDLE);
      end else begin
        m[0] = mstep(m[0], TO0, START, P_0, Z_IN, ACK);
        m[1] = mstep(m[1], TO1, START, P_0, Z_IN, ACK);
      end
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CK) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m[i].ph == M_CAPT || m[i].ph == M_CAPT2));
      check($sformatf("done%0d", i), 32'(done_o[i]), 32'(m[i].ph == M_DONE));
      check($sformatf("err%0d", i), 32'(err[i]), 32'(m[i].err));
      check($sformatf("mismatch%0d", i), 32'(mis[i]), 32'(m[i].mis));
      check($sformatf("mask%0d", i), 32'(mask[i]), 32'(m[i].bits));
      check($sformatf("step%0d", i), 32'(step[i]), m[i].idx);
      check($sformatf("busy_done_excl%0d", i), 32'(busy[i] & done_o[i]), 32'd0);
    end
  end

  function automatic bit rnd();
    return bit'($urandom & 32'd1);
  endfunction

  // One clock cycle with the given inputs; returns 1 time unit after the edge
  task automatic cyc(input bit rn, input bit st, input bit p, input bit z, input bit ack);
    RN = rn; START = st; P_0 = p; Z_IN = z; ACK = ack;
    @(posedge CK);
    #1;
  endtask

  task automatic pass(input logic [16:0] c, input int gap, input int from, input int upto);
    for (int k = from; k <= upto; k++) begin
      repeat (gap) cyc(1'b1, 1'b0, 1'b0, rnd(), 1'b0);
      cyc(1'b1, 1'b0, 1'b1, c[k], 1'b0);
    end
  endtask

  task automatic lit(input string n, input int i, input logic eb, input logic ed, input logic ee,
                     input logic em, input logic [16:0] emask, input logic [4:0] estep);
    check({n, "_busy"}, 32'(busy[i]), 32'(eb));
    check({n, "_done"}, 32'(done_o[i]), 32'(ed));
    check({n, "_err"}, 32'(err[i]), 32'(ee));
    check({n, "_mismatch"}, 32'(mis[i]), 32'(em));
    check({n, "_mask"}, 32'(mask[i]), 32'(emask));
    check({n, "_step"}, 32'(step[i]), 32'(estep));
  endtask

  logic [16:0] c3, c4;
  int pprob;

  initial begin
    repeat (2) @(posedge CK);
    #1;
    for (int i = 0; i < 2; i++) lit("reset", i, 0, 0, 0, 0, 17'h0, 5'd0);

    // Straight 17-step capture; release and START land on the same edge
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) lit("start", i, 1, 0, 0, 0, 17'h0, 5'd0);
    pass(17'h1_0005, 0, 0, 16);
    if (DOUBLE) pass(17'h1_0005, 0, 0, 16);
    for (int i = 0; i < 2; i++) lit("straight", i, 0, 1, 0, 0, 17'h1_0005, 5'd0);

    // ACK returns to IDLE with MASK held
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) lit("ack_hold", i, 0, 0, 0, 0, 17'h1_0005, 5'd0);

    // Same capture with 3 idle cycles before each step
    cyc(1, 1, 0, 0, 0);
    pass(17'h1_0005, 3, 0, 16);
    if (DOUBLE) pass(17'h1_0005, 3, 0, 16);
    for (int i = 0; i < 2; i++) lit("gapped", i, 0, 1, 0, 0, 17'h1_0005, 5'd0);

    // Timeout: 5 steps then P_0 low; the TIMEOUT=4 instance aborts on idle cycle 4
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    pass(17'h1_0015, 0, 0, 4);
    repeat (3) cyc(1, 0, 0, rnd(), 0);
    lit("to_idle3", 1, 1, 0, 0, 0, 17'h0_0015, 5'd5);
    cyc(1, 0, 0, rnd(), 0);
    lit("to_abort", 1, 0, 1, 1, 0, 17'h0_0015, 5'd5);
    lit("to_long", 0, 1, 0, 0, 0, 17'h0_0015, 5'd5);
    pass(17'h1_0015, 0, 5, 16);
    if (DOUBLE) pass(17'h1_0015, 0, 0, 16);
    lit("to_finish", 0, 0, 1, 0, 0, 17'h1_0015, 5'd0);
    lit("to_stay", 1, 0, 1, 1, 0, 17'h0_0015, 5'd5);

    // START and ACK together in DONE: restart wins and clears the flags
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) lit("start_ack", i, 1, 0, 0, 0, 17'h0, 5'd0);

    // START during capture has no effect
    c3 = 17'($urandom);
    for (int k = 0; k <= 8; k++) cyc(1, (k >= 3 && k <= 5), 1, c3[k], 0);
    for (int i = 0; i < 2; i++) lit("mid_start", i, 1, 0, 0, 0, c3 & 17'h0_01FF, 5'd9);

    // Asynchronous reset mid-capture, then a fresh capture
    RN = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) lit("async_rst", i, 0, 0, 0, 0, 17'h0, 5'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) lit("rst_restart", i, 1, 0, 0, 0, 17'h0, 5'd0);
    c4 = 17'($urandom);
    pass(c4, 0, 0, 16);
    if (DOUBLE) pass(c4, 0, 0, 16);
    for (int i = 0; i < 2; i++) lit("fresh", i, 0, 1, 0, 0, c4, 5'd0);

    if (DOUBLE) begin
      // Verify pass differing only at bit 3
      cyc(1, 1, 0, 0, 0);
      pass(17'h0_00FF, 0, 0, 16);
      pass(17'h0_00F7, 0, 0, 15);
      for (int i = 0; i < 2; i++) lit("dp_33", i, 1, 0, 0, 1, 17'h0_00FF, 5'd16);
      pass(17'h0_00F7, 0, 16, 16);
      for (int i = 0; i < 2; i++) lit("dp_diff", i, 0, 1, 0, 1, 17'h0_00FF, 5'd0);
      cyc(1, 1, 0, 0, 0);
      pass(17'h0_00FF, 0, 0, 16);
      pass(17'h0_00FF, 0, 0, 16);
      for (int i = 0; i < 2; i++) lit("dp_same", i, 0, 1, 0, 0, 17'h0_00FF, 5'd0);
    end

    // Randomised traffic with varying step density and occasional resets
    pprob = 90;
    for (int n = 0; n < 6000; n++) begin
      if (n % 400 == 0) begin
        case ($urandom_range(0, 2))
          0:       pprob = 95;
          1:       pprob = 50;
          default: pprob = 1;
        endcase
      end
      cyc(($urandom_range(0, 999) >= 3), ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < pprob), rnd(), ($urandom_range(0, 99) < 15));
    end

    cyc(1, 0, 0, 0, 0);
    @(negedge CK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
